// File: rtl/int8_div_seq.sv
// int8_div_seq: sequential radix-4 divider, 16-bit dividend / 8-bit divisor -> 8-bit quotient + remainder.
// Define INT8_DIV_SIGNED_EN for two's-complement operands with truncating division.
module int8_div_seq #(
   parameter bit HOLD_RSLT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iEn,
   input  logic [15:0] iDvd,
   input  logic [7:0]  iDvs,
   output logic        oBusy,
   output logic        oVld,
   output logic [7:0]  oQuo,
   output logic [7:0]  oRem,
   output logic        oOvf
);
   typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;

   state_t      state, state_nx;
   logic [1:0]  cnt;
   logic        busy, accept;
   logic [15:0] dvd_in;
   logic [7:0]  dvs_in;
   logic [15:0] mag_dvd;
   logic [7:0]  mag_dvs;
   logic [7:0]  d1;
   logic [8:0]  d2;
   logic [9:0]  d3;
   logic [7:0]  r, lo, quo;
   logic        err;
   logic [9:0]  x;
   logic [1:0]  q;
   logic [7:0]  r_nx;
   logic [7:0]  res_quo, res_rem;
   logic        res_ovf;
   logic        vld_r, ovf_r;
   logic [7:0]  quo_r, rem_r;

   assign busy   = (state == PRE) || (state == ITER);
   assign accept = iEn && !busy;

`ifdef INT8_DIV_SIGNED_EN
   logic       neg_q, neg_r, sovf;
   logic [7:0] sq, sr;
   assign mag_dvd = dvd_in[15] ? 16'(-dvd_in) : dvd_in;
   assign mag_dvs = dvs_in[7]  ? 8'(-dvs_in)  : dvs_in;
   assign neg_q   = dvd_in[15] ^ dvs_in[7];
   assign neg_r   = dvd_in[15];
   assign sq      = neg_q ? 8'(-quo) : quo;
   assign sr      = neg_r ? 8'(-r)   : r;
   // -128 is representable, +128 is not
   assign sovf    = neg_q ? (quo > 8'd128) : (quo > 8'd127);
`else
   assign mag_dvd = dvd_in;
   assign mag_dvs = dvs_in;
`endif

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // next state
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = PRE;
         PRE:     state_nx = ITER;
         ITER:    if (cnt == 2'd3) state_nx = DONE;
         DONE:    state_nx = accept ? PRE : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // one radix-4 step: pick the largest multiple that fits under X
   always_comb begin
      x = {r, lo[7:6]};
      if (x >= d3) begin
         q = 2'd3; r_nx = 8'(x - d3);
      end else if (x >= {1'b0, d2}) begin
         q = 2'd2; r_nx = 8'(x - {1'b0, d2});
      end else if (x >= {2'b0, d1}) begin
         q = 2'd1; r_nx = 8'(x - {2'b0, d1});
      end else begin
         q = 2'd0; r_nx = x[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dvd_in <= '0; dvs_in <= '0;
         d1 <= '0; d2 <= '0; d3 <= '0;
         r <= '0; lo <= '0; quo <= '0; err <= 1'b0; cnt <= '0;
      end else begin
         if (accept) begin
            dvd_in <= iDvd;
            dvs_in <= iDvs;
         end
         case (state)
            PRE: begin
               d1  <= mag_dvs;
               d2  <= {mag_dvs, 1'b0};
               d3  <= {2'b0, mag_dvs} + {1'b0, mag_dvs, 1'b0};
               r   <= mag_dvd[15:8];
               lo  <= mag_dvd[7:0];
               err <= (mag_dvs == 8'd0) || (mag_dvd[15:8] >= mag_dvs);
               quo <= '0;
               cnt <= '0;
            end
            ITER: begin
               r   <= r_nx;
               lo  <= {lo[5:0], 2'b00};
               quo <= {quo[5:0], q};
               cnt <= cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      res_quo = quo;
      res_rem = r;
      res_ovf = 1'b0;
`ifdef INT8_DIV_SIGNED_EN
      res_quo = sq;
      res_rem = sr;
      if (!err && sovf) begin
         res_quo = neg_q ? 8'h80 : 8'h7F;
         res_rem = dvd_in[7:0];
         res_ovf = 1'b1;
      end
`endif
      if (err) begin
         res_quo = 8'hFF;
         res_rem = dvd_in[7:0];
         res_ovf = 1'b1;
      end
   end

   // result formatted in DONE, presented from the output registers on the following cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_r <= 1'b0; quo_r <= '0; rem_r <= '0; ovf_r <= 1'b0;
      end else begin
         vld_r <= (state == DONE);
         if (state == DONE) begin
            quo_r <= res_quo;
            rem_r <= res_rem;
            ovf_r <= res_ovf;
         end
      end
   end

   // outputs
   always_comb begin
      oBusy = busy;
      oVld  = vld_r;
      oQuo  = quo_r;
      oRem  = rem_r;
      oOvf  = ovf_r;
      if (!HOLD_RSLT && !vld_r) begin
         oQuo = '0;
         oRem = '0;
         oOvf = 1'b0;
      end
   end
endmodule
